// File: rtl/five_bit_pkg.sv
// Shared constants and FSM state type for the five-bit serial receiver.
package five_bit_pkg;

    localparam int FIVE_BIT_WIDTH = 5;
    localparam logic IDLE_LVL = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/five_bit_shifter.sv
// Indexed-load shift register: writes one bit at position idx_i per enabled cycle.
module five_bit_shifter #(
    parameter int WIDTH = 5,
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clock) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q[idx_i] <= bit_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/five_bit_rx.sv
// Framed serial receiver: start, WIDTH data bits LSB first, optional even parity, stop.
// Define FIVE_BIT_RX_PARITY_EN to add the parity bit and its check.
module five_bit_rx
    import five_bit_pkg::*;
#(
    parameter int WIDTH = FIVE_BIT_WIDTH
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             bit_valid,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             frame_error,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rx_state_e        state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] word_q;
    logic             word_valid_q;
    logic             frame_error_q;
    logic             busy_q;
    logic [WIDTH-1:0] shift_data;
    logic             start_seen;
    logic             last_bit;
`ifdef FIVE_BIT_RX_PARITY_EN
    logic             par_q;
    logic             par_bad_q;
`endif

    assign start_seen = bit_valid && (state_q == IDLE) && (serial_in != IDLE_LVL);
    assign last_bit   = (count_q == CNT_W'(WIDTH - 1));

    // Clearing on the start bit keeps a stale partial frame from leaking into the next word.
    five_bit_shifter #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_shift (
        .clock  (clock),
        .clr_i  (Reset || start_seen),
        .en_i   (bit_valid && (state_q == DATA)),
        .idx_i  (count_q),
        .bit_i  (serial_in),
        .data_o (shift_data)
    );

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef FIVE_BIT_RX_PARITY_EN
            par_q         <= 1'b0;
            par_bad_q     <= 1'b0;
`endif
        end else begin
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if (bit_valid) begin
                case (state_q)
                    IDLE: begin
                        if (serial_in != IDLE_LVL) begin
                            state_q   <= DATA;
                            count_q   <= '0;
                            busy_q    <= 1'b1;
`ifdef FIVE_BIT_RX_PARITY_EN
                            par_q     <= 1'b0;
                            par_bad_q <= 1'b0;
`endif
                        end
                    end
                    DATA: begin
                        count_q <= count_q + 1'b1;
`ifdef FIVE_BIT_RX_PARITY_EN
                        par_q   <= par_q ^ serial_in;
                        if (last_bit) state_q <= PARITY;
`else
                        if (last_bit) state_q <= STOP;
`endif
                    end
`ifdef FIVE_BIT_RX_PARITY_EN
                    PARITY: begin
                        par_bad_q <= (serial_in != par_q);
                        state_q   <= STOP;
                    end
`endif
                    STOP: begin
`ifdef FIVE_BIT_RX_PARITY_EN
                        if ((serial_in == IDLE_LVL) && !par_bad_q) begin
`else
                        if (serial_in == IDLE_LVL) begin
`endif
                            word_q       <= shift_data;
                            word_valid_q <= 1'b1;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign word_out    = word_q;
    assign word_valid  = word_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_five_bit_rx.sv
// Directed bench for five_bit_rx; honours FIVE_BIT_RX_PARITY_EN for frame layout.
module tb_five_bit_rx;

`ifdef FIVE_BIT_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT = 6 + PAR;

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       bit_valid = 1'b0;
    logic       serial_in = 1'b1;
    logic [4:0] word_out;
    logic       word_valid;
    logic       frame_error;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int smp = 0;
    int start_smp = 0;
    int p1 = 0;

    five_bit_rx dut (
        .clock       (clock),
        .Reset       (Reset),
        .bit_valid   (bit_valid),
        .serial_in   (serial_in),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic s);
        @(negedge clock);
        bit_valid = v;
        serial_in = s;
        @(posedge clock);
        #1;
        if (v && !Reset) smp++;
    endtask

    // Start bit, data LSB first, then the parity bit when enabled.
    task automatic send_head(input logic [4:0] w, input logic par, input int gap);
        step(1'b1, 1'b0);
        start_smp = smp;
        chk("busy_after_start", 32'(busy), 1);
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'b0);
                chk("busy_in_gap", 32'(busy), 1);
            end
            step(1'b1, w[i]);
        end
        if (PAR != 0) step(1'b1, par);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("rst_word_out", 32'(word_out), 0);
        chk("rst_word_valid", 32'(word_valid), 0);
        chk("rst_frame_error", 32'(frame_error), 0);
        chk("rst_busy", 32'(busy), 0);
        Reset = 1'b0;
        step(1'b1, 1'b1);
        chk("idle_stays", 32'(busy), 0);

        // Frame for 25
        send_head(5'd25, 1'b1, 0);
        step(1'b1, 1'b1);
        chk("f25_valid", 32'(word_valid), 1);
        chk("f25_word", 32'(word_out), 25);
        chk("f25_err", 32'(frame_error), 0);
        chk("f25_busy", 32'(busy), 0);
        chk("f25_latency", 32'(smp - start_smp), LAT);
        step(1'b0, 1'b1);
        chk("f25_valid_fall", 32'(word_valid), 0);

        // Bad stop bit on a frame for 11
        send_head(5'd11, 1'b1, 0);
        step(1'b1, 1'b0);
        chk("badstop_err", 32'(frame_error), 1);
        chk("badstop_valid", 32'(word_valid), 0);
        chk("badstop_word", 32'(word_out), 25);
        step(1'b1, 1'b1);
        chk("badstop_err_fall", 32'(frame_error), 0);
        chk("badstop_busy", 32'(busy), 0);

        // Gapped strobes, frame for 19
        send_head(5'd19, 1'b1, 3);
        chk("gap_busy_before_stop", 32'(busy), 1);
        step(1'b1, 1'b1);
        chk("gap_valid", 32'(word_valid), 1);
        chk("gap_word", 32'(word_out), 19);

        // Reset mid-frame
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        @(negedge clock);
        Reset = 1'b1;
        bit_valid = 1'b1;
        serial_in = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_word", 32'(word_out), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(frame_error), 0);
        Reset = 1'b0;
        send_head(5'd11, 1'b1, 0);
        step(1'b1, 1'b1);
        chk("after_rst_valid", 32'(word_valid), 1);
        chk("after_rst_word", 32'(word_out), 11);

`ifdef FIVE_BIT_RX_PARITY_EN
        send_head(5'd25, 1'b1, 0);
        step(1'b1, 1'b1);
        chk("par_good_valid", 32'(word_valid), 1);
        chk("par_good_word", 32'(word_out), 25);
        send_head(5'd19, 1'b0, 0);
        step(1'b1, 1'b1);
        chk("par_bad_err", 32'(frame_error), 1);
        chk("par_bad_valid", 32'(word_valid), 0);
        chk("par_bad_word", 32'(word_out), 25);
`endif

        // Back-to-back frames, no idle samples between them
        send_head(5'd25, 1'b1, 0);
        step(1'b1, 1'b1);
        chk("b2b_first_valid", 32'(word_valid), 1);
        chk("b2b_first_word", 32'(word_out), 25);
        p1 = smp;
        send_head(5'd19, 1'b1, 0);
        chk("b2b_first_fall", 32'(word_valid), 0);
        step(1'b1, 1'b1);
        chk("b2b_second_valid", 32'(word_valid), 1);
        chk("b2b_second_word", 32'(word_out), 19);
        chk("b2b_spacing", 32'(smp - p1), 7 + PAR);
        step(1'b0, 1'b1);
        chk("b2b_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/five_bit_rx.md
# five_bit_rx

Serial framed receiver that assembles 5-bit words from a one-bit sampled line and presents each completed word, with a one-cycle valid strobe, to the 5-bit register stage that sits directly downstream. Bits are taken only on cycles qualified by `bit_valid`. Frames are start bit, 5 data bits LSB first, an optional even-parity bit, then a stop bit. Bad frames are dropped and flagged; the last good word is held.

## Interface
- `WIDTH`, default 5: data bits per frame; the downstream stage fixes this at 5.
- `clock`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `bit_valid`  in  1  sample strobe; `serial_in` is consumed only on edges where this is 1.
- `serial_in`  in  1  serial line; idles at 1.
- `word_out`  out  WIDTH  last correctly received word; held until the next good frame.
- `word_valid`  out  1  one-cycle pulse: `word_out` was just updated.
- `frame_error`  out  1  one-cycle pulse: frame rejected (bad stop bit or, if enabled, bad parity).
- `busy`  out  1  high while a frame is in progress (state not IDLE).

## Operation
- FSM states: IDLE, DATA, PARITY (present only with parity enabled), STOP.
- IDLE: on `bit_valid` and `serial_in`=0 (start bit), go to DATA, clear bit count and parity accumulator. `serial_in`=1 stays IDLE.
- DATA: each qualified bit goes into shift-register position `count` (LSB first) and is XORed into the parity accumulator. After bit WIDTH-1, go to PARITY if enabled, else STOP.
- PARITY: expected bit = XOR of the data bits (even parity over data plus parity bit). A mismatch latches internal `par_bad`. Go to STOP.
- STOP: `serial_in`=1 and no `par_bad` loads the shift register into `word_out` and pulses `word_valid`. Otherwise pulse `frame_error` and leave `word_out` unchanged. Always return to IDLE.
- `bit_valid`=0 freezes state, count and shift register. There is no timeout.
- `word_valid` and `frame_error` are mutually exclusive and never high for two consecutive cycles from one frame.

## Timing
- Reset values: `word_out`=0, `word_valid`=0, `frame_error`=0, `busy`=0, state IDLE, count 0.
- `Reset` overrides `bit_valid` on the same edge. Reset mid-frame discards the partial frame with no error pulse.
- All outputs are registered.
- `word_valid` and `frame_error` rise on the edge that samples the stop bit and fall on the next edge.
- Latency from start-bit edge to `word_valid`: WIDTH+1 qualified samples, or WIDTH+2 with parity.
- Back-to-back frames: a start bit on the very next qualified sample after the stop bit is accepted. IDLE is re-entered on the stop edge.
- `busy` rises on the start-bit edge and falls on the stop-bit edge.

## Configuration
- `FIVE_BIT_RX_PARITY_EN` defined: PARITY state exists, the frame carries an even-parity bit after the data, and a parity mismatch produces `frame_error`.
- Not defined: no PARITY state and no parity logic; DATA goes directly to STOP, and the frame is start + WIDTH data + stop.

## Structure
- Shared package `five_bit_pkg` holds:
  - the `WIDTH` default constant (5);
  - the FSM state enum typedef (IDLE, DATA, PARITY, STOP);
  - the idle-line level constant (1).
- One sub-module, `five_bit_shifter`: WIDTH-bit indexed-load shift register with enable and synchronous clear.
- The FSM, counter, parity accumulator and output registers stay in `five_bit_rx`.

## Test plan
- Frame for 25 without parity: samples 0,1,0,0,1,1,1 with `bit_valid`=1 -> `word_out`=25 and `word_valid` high one cycle after the stop edge; `busy` low again.
- Bad stop bit: frame for 11 (0,1,1,0,1,0) followed by stop 0 -> `frame_error` pulses once, `word_out` stays 25, `word_valid` stays 0.
- Gapped strobes: frame for 19 (0,1,1,0,0,1,1) with `bit_valid` low for 3 cycles between each bit -> `word_out`=19; state holds during the gaps.
- Reset mid-frame: start plus 2 data bits, then `Reset`=1 for one cycle -> all outputs 0, IDLE. A subsequent full frame for 11 yields `word_out`=11.
- With `FIVE_BIT_RX_PARITY_EN`:
  - frame for 25 with parity 1 -> `word_valid`, `word_out`=25;
  - same frame with parity 0 -> `frame_error`, `word_out` unchanged.
- Back-to-back frames for 25 then 19 with no idle samples -> two `word_valid` pulses 7 qualified samples apart (8 with parity); `word_out` reads 25, then 19.
